// File: rtl/alu_op_sequencer_if.sv
// Command, datapath-control and response signals of the ALU op sequencer.
// The slave modport belongs to the sequencer. The master modport belongs to
// the environment: the command source, the datapath and the response consumer.
//
// Handshakes (cmd_* and rsp_*): a transfer happens on a rising clock edge
// where valid and ready are both high. Once valid is raised it stays high,
// with its payload stable, until that transfer. Ready may change freely.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] operand_out;
  logic             Eo;
  logic             nLa;
  logic             nLb;
  logic             Ea;
  logic             Eu;
  logic             sub;
  logic [WIDTH-1:0] bus_in;
  logic             cf_in;
  logic             zf_in;
  logic             flag_c;
  logic             flag_z;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, bus_in, cf_in, zf_in, rsp_ready,
    output cmd_ready, operand_out, Eo, nLa, nLb, Ea, Eu, sub,
           flag_c, flag_z, rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, bus_in, cf_in, zf_in, rsp_ready,
    input  cmd_ready, operand_out, Eo, nLa, nLb, Ea, Eu, sub,
           flag_c, flag_z, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Control sequencer for the accumulator/ALU datapath. The sequencer accepts
// one command at a time. It walks the shared bus through the load and execute
// phases for that command, latches the ALU flags, and returns the captured bus
// value on the response channel. All datapath controls are registered and
// decoded from the next state, so each control changes together with the
// state.
module alu_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus_if,
  output logic [2:0]          state_o
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OUT = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDB  = 3'd1,
    S_EXE  = 3'd2,
    S_LDA  = 3'd3,
    S_CLR  = 3'd4,
    S_OUTA = 3'd5,
    S_RSP  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] operand_q;
  logic             eo_q, ea_q, eu_q, nla_q, nlb_q, sub_q;
  logic             flag_c_q, flag_z_q;
  logic             rsp_valid_q, rsp_err_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             cmd_ready;
  logic             accept;

  // Ready is held low while reset is asserted, even though the state is already IDLE.
  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = bus_if.cmd_valid && cmd_ready;

  // Next-state selection: dispatch on the opcode at accept, one cycle per phase, and wait in RSP for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus_if.cmd_op)
            OP_NOP:         state_d = S_RSP;
            OP_LDA:         state_d = S_LDA;
            OP_ADD, OP_SUB: state_d = S_LDB;
            OP_OUT:         state_d = S_OUTA;
            OP_CLR:         state_d = S_CLR;
            default:        state_d = S_RSP;
          endcase
        end
      end
      S_LDB:                      state_d = S_EXE;
      S_EXE, S_LDA, S_CLR, S_OUTA: state_d = S_RSP;
      S_RSP:   if (bus_if.rsp_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // FSM state, registered datapath controls, and the flag/response captures at the end of each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      operand_q   <= '0;
      eo_q        <= 1'b0;
      ea_q        <= 1'b0;
      eu_q        <= 1'b0;
      nla_q       <= 1'b1;
      nlb_q       <= 1'b1;
      sub_q       <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      eo_q        <= (state_d == S_LDB) || (state_d == S_LDA) || (state_d == S_CLR);
      ea_q        <= (state_d == S_OUTA);
      eu_q        <= (state_d == S_EXE);
      nla_q       <= !((state_d == S_EXE) || (state_d == S_LDA) || (state_d == S_CLR));
      nlb_q       <= !(state_d == S_LDB);
      // op_q was captured at accept, so it is already valid when EXE is entered from LDB.
      sub_q       <= (state_d == S_EXE) && (op_q == OP_SUB);
      rsp_valid_q <= (state_d == S_RSP);

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q       <= bus_if.cmd_op;
            // For CLR, a zero operand is placed on the bus, which clears the accumulator.
            operand_q  <= (bus_if.cmd_op == OP_CLR) ? '0 : bus_if.cmd_data;
            rsp_data_q <= '0;
            rsp_err_q  <= (bus_if.cmd_op > OP_CLR);
          end
        end
        S_EXE: begin
          flag_c_q   <= bus_if.cf_in;
          flag_z_q   <= bus_if.zf_in;
          rsp_data_q <= bus_if.bus_in;
        end
        S_LDA, S_OUTA: rsp_data_q <= bus_if.bus_in;
        S_CLR: begin
          flag_c_q   <= 1'b0;
          flag_z_q   <= 1'b1;
          rsp_data_q <= '0;
        end
        S_RSP:   if (bus_if.rsp_ready) rsp_err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus_if.cmd_ready   = cmd_ready;
  assign bus_if.operand_out = operand_q;
  assign bus_if.Eo          = eo_q;
  assign bus_if.Ea          = ea_q;
  assign bus_if.Eu          = eu_q;
  assign bus_if.nLa         = nla_q;
  assign bus_if.nLb         = nlb_q;
  assign bus_if.sub         = sub_q;
  assign bus_if.flag_c      = flag_c_q;
  assign bus_if.flag_z      = flag_z_q;
  assign bus_if.rsp_valid   = rsp_valid_q;
  assign bus_if.rsp_data    = rsp_data_q;
  assign bus_if.rsp_err     = rsp_err_q;
  assign bus_if.busy        = (state_q != S_IDLE);
  assign state_o            = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer. A small accumulator/B-register/ALU
// model sits on the bus and is driven only by the sequencer's controls. A
// vector table gives each command with its hand-computed response, flags,
// latency and control-pulse counts. Hand-written sequences cover backpressure
// and reset in the middle of an operation.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] state_dbg;

  int compared   = 0;
  int mismatched = 0;

  alu_op_sequencer_if #(.WIDTH(8)) bif ();

  alu_op_sequencer #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus_if  (bif),
    .state_o (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // Datapath model: accumulator A, register B, and an ALU that computes A + B or A + ~B + 1.
  logic [7:0] acc_m = 8'h00;
  logic [7:0] b_m   = 8'h00;
  logic [8:0] alu_sum;

  always_comb begin
    alu_sum = {1'b0, acc_m} + {1'b0, (bif.sub ? ~b_m : b_m)} + {8'b0, bif.sub};
    bif.bus_in = 8'h00;
    if (bif.Eo)      bif.bus_in = bif.operand_out;
    else if (bif.Ea) bif.bus_in = acc_m;
    else if (bif.Eu) bif.bus_in = alu_sum[7:0];
  end

  assign bif.cf_in = alu_sum[8];
  assign bif.zf_in = (alu_sum[7:0] == 8'h00);

  // Register loads in the model, taken on the same edge the sequencer uses.
  always @(posedge clk) begin
    if (!bif.nLa) acc_m <= bif.bus_in;
    if (!bif.nLb) b_m   <= bif.bus_in;
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_err;
    logic       exp_c;
    logic       exp_z;
    int         exp_lat;
    int         exp_pulses;  // decimal digits: Eo Ea Eu nLa-low nLb-low sub
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"},   {29'd0, state_dbg}, 32'd0);
    chk({tag, "_ctrl"},    {26'd0, bif.Eo, bif.Ea, bif.Eu, bif.sub, bif.nLa, bif.nLb}, 32'b000011);
    chk({tag, "_flags"},   {30'd0, bif.flag_c, bif.flag_z}, 32'd0);
    chk({tag, "_rsp"},     {22'd0, bif.rsp_valid, bif.rsp_err, bif.rsp_data}, 32'd0);
    chk({tag, "_operand"}, {24'd0, bif.operand_out}, 32'd0);
    chk({tag, "_ready"},   {30'd0, bif.cmd_ready, bif.busy}, 32'd0);
  endtask

  task automatic check_invariants(input string tag);
    chk({tag, "_one_enable"}, {31'd0, (32'($countones({bif.Eo, bif.Ea, bif.Eu})) <= 1)}, 32'd1);
    chk({tag, "_loads"},      {31'd0, (bif.nLa || bif.nLb)}, 32'd1);
  endtask

  // Bounded wait for rsp_valid, sampled at negedges. Returns the number of cycles spent.
  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!bif.rsp_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Drive one command, count control pulses until the response arrives, check it, then complete the handshake.
  task automatic run_cmd(input vec_t v, input string tag);
    int n;
    int lat;
    int c_eo, c_ea, c_eu, c_nla, c_nlb, c_sub;
    n = 0;
    while (!bif.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_cmd_ready"}, {31'd0, bif.cmd_ready}, 32'd1);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = v.op;
    bif.cmd_data  = v.data;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    lat = 1;
    c_eo = 0; c_ea = 0; c_eu = 0; c_nla = 0; c_nlb = 0; c_sub = 0;
    while (!bif.rsp_valid && lat < 20) begin
      check_invariants(tag);
      c_eo  += int'(bif.Eo);
      c_ea  += int'(bif.Ea);
      c_eu  += int'(bif.Eu);
      c_nla += int'(!bif.nLa);
      c_nlb += int'(!bif.nLb);
      c_sub += int'(bif.sub);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_rsp_valid"}, {31'd0, bif.rsp_valid}, 32'd1);
    chk({tag, "_latency"},   lat, v.exp_lat);
    chk({tag, "_pulses"},    c_eo * 100000 + c_ea * 10000 + c_eu * 1000 + c_nla * 100 + c_nlb * 10 + c_sub,
        v.exp_pulses);
    chk({tag, "_data"},      {24'd0, bif.rsp_data}, {24'd0, v.exp_data});
    chk({tag, "_err"},       {31'd0, bif.rsp_err}, {31'd0, v.exp_err});
    chk({tag, "_flags"},     {30'd0, bif.flag_c, bif.flag_z}, {30'd0, v.exp_c, v.exp_z});
    chk({tag, "_rsp_idle"},  {26'd0, bif.Eo, bif.Ea, bif.Eu, bif.sub, bif.nLa, bif.nLb, bif.cmd_ready},
        32'b0000110);
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    bif.rsp_ready = 1'b0;
    chk({tag, "_after_hs"}, {28'd0, bif.rsp_valid, bif.rsp_err, state_dbg == 3'd0, bif.cmd_ready}, 32'b0011);
  endtask

  initial begin
    int cyc;
    vec_t v;

    bif.cmd_valid = 1'b0;
    bif.cmd_op    = 3'd0;
    bif.cmd_data  = 8'h00;
    bif.rsp_ready = 1'b0;

    // Reset
    #2 rst = 1'b1;
    #1 check_reset_vals("reset");
    repeat (2) @(negedge clk);
    check_reset_vals("reset_hold");
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, applied in order; the accumulator carries over from one vector to the next.
    //            op     data   rsp    err   c     z     lat pulses
    tbl[0]  = '{3'd1, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 2, 100100};  // LDA 05
    tbl[1]  = '{3'd2, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 3, 101110};  // ADD 03 -> 08
    tbl[2]  = '{3'd3, 8'h08, 8'h00, 1'b0, 1'b1, 1'b1, 3, 101111};  // SUB 08 -> 00, no borrow
    tbl[3]  = '{3'd1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 2, 100100};  // LDA FF, flags kept
    tbl[4]  = '{3'd2, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 3, 101110};  // ADD 01 wraps
    tbl[5]  = '{3'd4, 8'h99, 8'h00, 1'b0, 1'b1, 1'b1, 2, 010000};  // OUT
    tbl[6]  = '{3'd1, 8'h30, 8'h30, 1'b0, 1'b1, 1'b1, 2, 100100};  // LDA 30
    tbl[7]  = '{3'd3, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 3, 101111};  // SUB 10 -> 20
    tbl[8]  = '{3'd3, 8'h40, 8'hE0, 1'b0, 1'b0, 1'b0, 3, 101111};  // SUB 40 -> E0, borrow
    tbl[9]  = '{3'd5, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 2, 100100};  // CLR
    tbl[10] = '{3'd0, 8'h77, 8'h00, 1'b0, 1'b0, 1'b1, 1, 000000};  // NOP
    tbl[11] = '{3'd7, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b1, 1, 000000};  // illegal 7
    tbl[12] = '{3'd6, 8'h55, 8'h00, 1'b1, 1'b0, 1'b1, 1, 000000};  // illegal 6
    tbl[13] = '{3'd4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2, 010000};  // OUT after CLR
    tbl[14] = '{3'd2, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 3, 101110};  // ADD 7F -> 7F

    for (int i = 0; i < 15; i++) begin
      run_cmd(tbl[i], $sformatf("vec%0d", i));
    end

    // Backpressure: the response is held for 5 cycles while a second command waits.
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = 3'd1;
    bif.cmd_data  = 8'h5A;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    wait_rsp(cyc);
    chk("bp_first_rsp", {31'd0, bif.rsp_valid}, 32'd1);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = 3'd1;
    bif.cmd_data  = 8'h11;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), {22'd0, bif.rsp_valid, bif.cmd_ready, bif.rsp_data}, {22'd0, 2'b10, 8'h5A});
      @(negedge clk);
    end
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    bif.rsp_ready = 1'b0;
    chk("bp_idle_after_hs", {28'd0, state_dbg, bif.cmd_ready}, {28'd0, 3'd0, 1'b1});
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    chk("bp_second_accept", {29'd0, state_dbg}, 32'd3);
    wait_rsp(cyc);
    chk("bp_second_data", {23'd0, bif.rsp_valid, bif.rsp_data}, {23'd0, 1'b1, 8'h11});
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    bif.rsp_ready = 1'b0;

    // Reset asserted during the EXE cycle of an ADD.
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = 3'd2;
    bif.cmd_data  = 8'h01;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    chk("mid_ldb", {29'd0, bif.Eo, bif.nLb, bif.Eu}, 32'b100);
    @(negedge clk);
    chk("mid_exe", {29'd0, bif.Eu, bif.nLa, bif.Eo}, 32'b100);
    rst = 1'b1;
    #1 check_reset_vals("mid_reset");
    @(negedge clk);
    check_reset_vals("mid_reset_hold");
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {30'd0, bif.cmd_ready, bif.rsp_valid}, 32'b10);
    v = '{3'd1, 8'h42, 8'h42, 1'b0, 1'b0, 1'b0, 2, 100100};
    run_cmd(v, "post_reset_lda");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
